// File: rtl/p2s_lane_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_lane_arbiter_pkg
//  Description : Lane symbol constants, state encoding and round-robin pick
//                shared by the lane arbiter, P2S and S2P blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package p2s_lane_arbiter_pkg;

    localparam int               LANE_WIDTH = 8;
    localparam logic [7:0]       LANE_COM   = 8'hBC;
    localparam logic [7:0]       LANE_IDLE  = 8'h7C;

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } lane_state_t;

    // Returns the channel to serve; when both hold data the one not served last wins.
    function automatic logic rr_pick(input logic full0, input logic full1,
                                     input logic last_grant);
        if (full0 && full1) begin
            return ~last_grant;
        end
        return full1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p2s_lane_if.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_lane_if
//  Description : Two byte channels in, one lane symbol stream out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface p2s_lane_if import p2s_lane_arbiter_pkg::*; #(
    parameter int WIDTH = LANE_WIDTH
) ();

    logic [WIDTH-1:0] data_in0;
    logic             valid_in0;
    logic             ready_out0;
    logic [WIDTH-1:0] data_in1;
    logic             valid_in1;
    logic             ready_out1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             grant_out;
    logic             active_out;

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output ready_out0, ready_out1, data_out, valid_out, grant_out, active_out
    );

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  ready_out0, ready_out1, data_out, valid_out, grant_out, active_out
    );

endinterface
`default_nettype wire

// File: rtl/p2s_lane_arbiter_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : lane_hold_buf
//  Description : One-entry channel holding register with full flag and a
//                registered ready that stays low while the entry is occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_hold_buf #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] in_data,
    input  wire logic             in_valid,
    input  wire logic             drain,
    output logic                  ready,
    output logic                  full,
    output logic [WIDTH-1:0]      data
);

    logic             r_ready;
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;
    logic             w_full_next;

    assign w_accept    = in_valid & r_ready;
    assign w_full_next = (r_full & ~drain) | w_accept;

    // Ready follows the next full value, so a slot drained this edge reopens only next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= enable & ~w_full_next;
            if (w_accept) begin
                r_data <= in_data;
            end
        end
    end

    assign ready = r_ready;
    assign full  = r_full;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/p2s_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_lane_arbiter
//  Description : Sends a COM training burst after reset, then round-robin
//                shares the serializer lane between two buffered channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module p2s_lane_arbiter import p2s_lane_arbiter_pkg::*; #(
    parameter int               WIDTH        = LANE_WIDTH,
    parameter int               TRAIN_CYCLES = 4,
    parameter logic [WIDTH-1:0] COM          = WIDTH'(LANE_COM),
    parameter logic [WIDTH-1:0] IDLE         = WIDTH'(LANE_IDLE)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    p2s_lane_if.slave   lane
);

    localparam int               CNT_W      = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_TRAIN = CNT_W'(TRAIN_CYCLES - 1);

    lane_state_t      r_state;
    logic [CNT_W-1:0] r_train_cnt;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_grant_out;
    logic             r_active_out;

    logic             w_train_done;
    logic             w_enable_next;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_full0;
    logic             w_full1;
    logic [WIDTH-1:0] w_buf_data0;
    logic [WIDTH-1:0] w_buf_data1;
    logic             w_any;
    logic             w_pick;
    logic             w_drain0;
    logic             w_drain1;

    assign w_train_done  = (r_state == TRAIN) && (r_train_cnt == LAST_TRAIN);
    assign w_enable_next = (r_state == ACTIVE) || w_train_done;

    // Eligibility uses the full flags as they stand at the start of the cycle.
    assign w_any    = w_full0 | w_full1;
    assign w_pick   = rr_pick(w_full0, w_full1, r_last_grant);
    assign w_drain0 = (r_state == ACTIVE) && w_any && !w_pick;
    assign w_drain1 = (r_state == ACTIVE) && w_any &&  w_pick;

    lane_hold_buf #(.WIDTH(WIDTH)) u_buf0 (
        .clk      (clk),
        .reset    (reset),
        .enable   (w_enable_next),
        .in_data  (lane.data_in0),
        .in_valid (lane.valid_in0),
        .drain    (w_drain0),
        .ready    (w_ready0),
        .full     (w_full0),
        .data     (w_buf_data0)
    );

    lane_hold_buf #(.WIDTH(WIDTH)) u_buf1 (
        .clk      (clk),
        .reset    (reset),
        .enable   (w_enable_next),
        .in_data  (lane.data_in1),
        .in_valid (lane.valid_in1),
        .drain    (w_drain1),
        .ready    (w_ready1),
        .full     (w_full1),
        .data     (w_buf_data1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= TRAIN;
            r_train_cnt  <= '0;
            r_last_grant <= 1'b1;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_grant_out  <= 1'b0;
            r_active_out <= 1'b0;
        end else begin
            case (r_state)
                TRAIN: begin
                    r_data_out  <= COM;
                    r_valid_out <= 1'b0;
                    r_train_cnt <= r_train_cnt + CNT_W'(1);
                    if (w_train_done) begin
                        r_state      <= ACTIVE;
                        r_active_out <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_any) begin
                        r_data_out   <= w_pick ? w_buf_data1 : w_buf_data0;
                        r_valid_out  <= 1'b1;
                        r_grant_out  <= w_pick;
                        r_last_grant <= w_pick;
                    end else begin
                        r_data_out  <= IDLE;
                        r_valid_out <= 1'b0;
                    end
                end
                default: begin
                    r_state <= TRAIN;
                end
            endcase
        end
    end

    assign lane.ready_out0 = w_ready0;
    assign lane.ready_out1 = w_ready1;
    assign lane.data_out   = r_data_out;
    assign lane.valid_out  = r_valid_out;
    assign lane.grant_out  = r_grant_out;
    assign lane.active_out = r_active_out;

endmodule
`default_nettype wire

// File: tb/tb_p2s_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p2s_lane_arbiter
//  Description : Directed self-checking bench for the lane arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_p2s_lane_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    p2s_lane_if lane ();

    p2s_lane_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .lane  (lane.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lane.valid_in0 = 1'b0;
        lane.valid_in1 = 1'b0;
        lane.data_in0  = 8'h00;
        lane.data_in1  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out, lane.active_out,
             lane.ready_out0, lane.ready_out1} !== {8'h00, 5'b00000}) begin
            miscompares++;
            $display("FAIL reset_state: got data=%h v=%b g=%b a=%b r0=%b r1=%b, want 00/0/0/0/0/0",
                     lane.data_out, lane.valid_out, lane.grant_out, lane.active_out,
                     lane.ready_out0, lane.ready_out1);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (lane.data_out !== 8'hBC || lane.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL train_sym[%0d]: got data=%h v=%b, want bc/0", i, lane.data_out, lane.valid_out);
            end
            if (i < 3) begin
                vectors++;
                if ({lane.active_out, lane.ready_out0, lane.ready_out1} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL train_flags[%0d]: got a/r0/r1=%b, want 000", i,
                             {lane.active_out, lane.ready_out0, lane.ready_out1});
                end
            end
        end
        vectors++;
        if ({lane.active_out, lane.ready_out0, lane.ready_out1} !== 3'b111) begin
            miscompares++;
            $display("FAIL train_end_flags: got a/r0/r1=%b, want 111",
                     {lane.active_out, lane.ready_out0, lane.ready_out1});
        end
        step();
        vectors++;
        if (lane.data_out !== 8'h7C || lane.valid_out !== 1'b0 || lane.active_out !== 1'b1) begin
            miscompares++;
            $display("FAIL first_idle: got data=%h v=%b a=%b, want 7c/0/1",
                     lane.data_out, lane.valid_out, lane.active_out);
        end
    endtask

    task automatic test_single_byte();
        lane.data_in0  = 8'hB5;
        lane.valid_in0 = 1'b1;
        step();
        lane.valid_in0 = 1'b0;
        vectors++;
        if (lane.ready_out0 !== 1'b0 || lane.data_out !== 8'h7C) begin
            miscompares++;
            $display("FAIL single_accept: got r0=%b data=%h, want 0/7c", lane.ready_out0, lane.data_out);
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'hB5, 2'b10}) begin
            miscompares++;
            $display("FAIL single_out: got data=%h v=%b g=%b, want b5/1/0",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'h7C, 2'b00}) begin
            miscompares++;
            $display("FAIL single_after: got data=%h v=%b g=%b, want 7c/0/0",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
    endtask

    task automatic test_simultaneous();
        // A ch1 byte first so that last_grant=1 going in.
        lane.data_in1  = 8'h11;
        lane.valid_in1 = 1'b1;
        step();
        lane.valid_in1 = 1'b0;
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'h11, 2'b11}) begin
            miscompares++;
            $display("FAIL sim_prime: got data=%h v=%b g=%b, want 11/1/1",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
        step();
        lane.data_in0  = 8'hD6;
        lane.valid_in0 = 1'b1;
        lane.data_in1  = 8'hB6;
        lane.valid_in1 = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if ({lane.ready_out0, lane.ready_out1} !== 2'b00) begin
            miscompares++;
            $display("FAIL sim_both_full: got r0/r1=%b, want 00", {lane.ready_out0, lane.ready_out1});
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'hD6, 2'b10}) begin
            miscompares++;
            $display("FAIL sim_first: got data=%h v=%b g=%b, want d6/1/0",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'hB6, 2'b11}) begin
            miscompares++;
            $display("FAIL sim_second: got data=%h v=%b g=%b, want b6/1/1",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'h7C, 2'b01}) begin
            miscompares++;
            $display("FAIL sim_after: got data=%h v=%b g=%b, want 7c/0/1",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
    endtask

    // Both sources stream 10 bytes each; lane output is A0,C0,A1,C1,... from the 2nd edge.
    task automatic test_back_to_back();
        int         idx0;
        int         idx1;
        logic       rdy0;
        logic       rdy1;
        logic [7:0] exp_data;
        logic       exp_grant;
        idx0 = 0;
        idx1 = 0;
        for (int s = 1; s <= 21; s++) begin
            lane.valid_in0 = (idx0 < 10);
            lane.data_in0  = 8'(8'hA0 + idx0);
            lane.valid_in1 = (idx1 < 10);
            lane.data_in1  = 8'(8'hC0 + idx1);
            rdy0 = lane.ready_out0;
            rdy1 = lane.ready_out1;
            step();
            if (lane.valid_in0 && rdy0) idx0++;
            if (lane.valid_in1 && rdy1) idx1++;
            vectors++;
            if (s == 1) begin
                if (lane.data_out !== 8'h7C || lane.valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_start: got data=%h v=%b, want 7c/0", lane.data_out, lane.valid_out);
                end
            end else begin
                exp_grant = 1'((s - 2) % 2);
                exp_data  = exp_grant ? 8'(8'hC0 + (s - 2) / 2) : 8'(8'hA0 + (s - 2) / 2);
                if ({lane.data_out, lane.valid_out, lane.grant_out} !== {exp_data, 1'b1, exp_grant}) begin
                    miscompares++;
                    $display("FAIL b2b_out[%0d]: got data=%h v=%b g=%b, want %h/1/%b",
                             s, lane.data_out, lane.valid_out, lane.grant_out, exp_data, exp_grant);
                end
            end
        end
        idle_inputs();
        vectors++;
        if (idx0 != 10 || idx1 != 10) begin
            miscompares++;
            $display("FAIL b2b_accepted: got ch0=%0d ch1=%0d, want 10/10", idx0, idx1);
        end
        step();
        vectors++;
        if (lane.data_out !== 8'h7C || lane.valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got data=%h v=%b, want 7c/0", lane.data_out, lane.valid_out);
        end
    endtask

    task automatic test_single_stream();
        int         idx;
        logic       rdy;
        logic [7:0] exp_data;
        logic       exp_rdy;
        idx = 0;
        for (int s = 1; s <= 8; s++) begin
            lane.valid_in1 = (idx < 4);
            lane.data_in1  = 8'(8'h51 + idx);
            rdy = lane.ready_out1;
            step();
            if (lane.valid_in1 && rdy) idx++;
            exp_rdy  = (s % 2 == 0);
            exp_data = exp_rdy ? 8'(8'h51 + s / 2 - 1) : 8'h7C;
            vectors++;
            if ({lane.ready_out1, lane.data_out, lane.valid_out} !== {exp_rdy, exp_data, exp_rdy}) begin
                miscompares++;
                $display("FAIL stream1[%0d]: got r1=%b data=%h v=%b, want %b/%h/%b",
                         s, lane.ready_out1, lane.data_out, lane.valid_out, exp_rdy, exp_data, exp_rdy);
            end
        end
        idle_inputs();
        vectors++;
        if (idx != 4 || lane.grant_out !== 1'b1) begin
            miscompares++;
            $display("FAIL stream1_count: got accepted=%0d g=%b, want 4/1", idx, lane.grant_out);
        end
        step();
        vectors++;
        if (lane.data_out !== 8'h7C || lane.valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL stream1_after: got data=%h v=%b, want 7c/0", lane.data_out, lane.valid_out);
        end
    endtask

    task automatic test_mid_reset();
        // Serve ch0 once so last_grant=0 before the reset.
        lane.data_in0  = 8'hE0;
        lane.valid_in0 = 1'b1;
        step();
        lane.valid_in0 = 1'b0;
        step();
        vectors++;
        if ({lane.data_out, lane.grant_out} !== {8'hE0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_prime: got data=%h g=%b, want e0/0", lane.data_out, lane.grant_out);
        end
        lane.data_in0  = 8'hE1;
        lane.valid_in0 = 1'b1;
        lane.data_in1  = 8'hE2;
        lane.valid_in1 = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if ({lane.ready_out0, lane.ready_out1} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_full: got r0/r1=%b, want 00", {lane.ready_out0, lane.ready_out1});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out, lane.active_out,
             lane.ready_out0, lane.ready_out1} !== {8'h00, 5'b00000}) begin
            miscompares++;
            $display("FAIL mid_reset_state: got data=%h v=%b g=%b a=%b r0=%b r1=%b, want 00/0/0/0/0/0",
                     lane.data_out, lane.valid_out, lane.grant_out, lane.active_out,
                     lane.ready_out0, lane.ready_out1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (lane.data_out !== 8'hBC || lane.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_train[%0d]: got data=%h v=%b, want bc/0", i, lane.data_out, lane.valid_out);
            end
        end
        step();
        vectors++;
        if (lane.data_out !== 8'h7C || lane.valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_discard: got data=%h v=%b, want 7c/0", lane.data_out, lane.valid_out);
        end
        lane.data_in0  = 8'hF0;
        lane.valid_in0 = 1'b1;
        lane.data_in1  = 8'hF1;
        lane.valid_in1 = 1'b1;
        step();
        idle_inputs();
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'hF0, 2'b10}) begin
            miscompares++;
            $display("FAIL mid_first_grant: got data=%h v=%b g=%b, want f0/1/0",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
        step();
        vectors++;
        if ({lane.data_out, lane.valid_out, lane.grant_out} !== {8'hF1, 2'b11}) begin
            miscompares++;
            $display("FAIL mid_second_grant: got data=%h v=%b g=%b, want f1/1/1",
                     lane.data_out, lane.valid_out, lane.grant_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle_inputs();
        test_reset();
        test_single_byte();
        test_simultaneous();
        test_back_to_back();
        test_single_stream();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
